// File: rtl/fifo_to_stream.sv
// Read-side adapter for a synchronous-read FIFO: pops words and presents them
// on a valid/ready stream through a 2-entry buffer that hides the read latency.
module fifo_to_stream #(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [data_width-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic [data_width-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  localparam logic [2:0] depth = 3'd2;

  logic [1:0]            count;
  logic                  inflight;
  logic [data_width-1:0] e0;
  logic [data_width-1:0] e1;
  logic                  pop;
  logic                  arr;
  logic [2:0]            credit_sum;

  assign data_out_valid = (count != 2'd0);
  assign data_out       = e0;
  assign pop            = data_out_valid && data_out_ready;
  assign arr            = inflight;

  // Words buffered plus in flight, minus the one leaving now, must leave room.
  assign credit_sum = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = rst && !fifo_empty && (credit_sum < depth);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= 2'd0;
      inflight <= 1'b0;
      e0       <= '0;
      e1       <= '0;
    end else begin
      inflight <= fifo_rd_en && !fifo_empty;
      case (count)
        2'd0: begin
          if (arr) begin
            e0    <= fifo_dout;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (arr && !pop) begin
            e1    <= fifo_dout;
            count <= 2'd2;
          end else if (arr && pop) begin
            e0 <= fifo_dout;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          // A full buffer only ever receives a word in a cycle that also pops.
          if (pop) begin
            e0 <= e1;
            if (arr) begin
              e1 <= fifo_dout;
            end else begin
              count <= 2'd1;
            end
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule
